// File: rtl/dfdd_seq_pkg.sv
// Shared state encoding, widths and config address map for the DfD frame sequencer.
package dfdd_seq_pkg;

  localparam int unsigned FP16_W  = 16;
  localparam int unsigned R2_W    = 18;
  localparam int unsigned COORD_W = 16;
  localparam int unsigned CFG_W   = 18;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, COMMIT} seq_state_t;

  // Config address = {region, index}
  localparam logic [3:0] RGN_W     = 4'h0;
  localparam logic [3:0] RGN_A0    = 4'h1;
  localparam logic [3:0] RGN_A1    = 4'h2;
  localparam logic [3:0] RGN_B0    = 4'h3;
  localparam logic [3:0] RGN_B1    = 4'h4;
  localparam logic [3:0] RGN_R2    = 4'h5;
  localparam logic [3:0] RGN_CONF  = 4'h6;
  localparam logic [3:0] RGN_DEPTH = 4'h7;
  localparam logic [3:0] RGN_CTR   = 4'h8;

  localparam logic [3:0] IDX_W_T        = 4'h6;
  localparam logic [3:0] IDX_COL_CENTER = 4'h0;
  localparam logic [3:0] IDX_ROW_CENTER = 4'h1;

endpackage

// File: rtl/dfdd_coef_bank.sv
// Shadow/active coefficient register file: address decode, unmapped-write
// error pulse and shadow-to-active copy on commit.
module dfdd_coef_bank
  import dfdd_seq_pkg::*;
#(
  parameter int unsigned NO_ZONES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [7:0]        cfg_addr_i,
  input  logic [CFG_W-1:0]  cfg_wdata_i,
  input  logic              commit_i,
  output logic              cfg_err_o,
  output logic [FP16_W-1:0] w_o          [2][3],
  output logic [FP16_W-1:0] w_t_o,
  output logic [FP16_W-1:0] a_o          [2][NO_ZONES],
  output logic [FP16_W-1:0] b_o          [2][NO_ZONES],
  output logic [R2_W-1:0]   r_squared_o  [NO_ZONES],
  output logic [FP16_W-1:0] confidence_o [NO_ZONES],
  output logic [FP16_W-1:0] depth_o      [NO_ZONES],
  output logic [FP16_W-1:0] col_center_o,
  output logic [FP16_W-1:0] row_center_o
);

  logic [FP16_W-1:0] w_sh     [2][3];
  logic [FP16_W-1:0] wt_sh;
  logic [FP16_W-1:0] a_sh     [2][NO_ZONES];
  logic [FP16_W-1:0] b_sh     [2][NO_ZONES];
  logic [R2_W-1:0]   r2_sh    [NO_ZONES];
  logic [FP16_W-1:0] conf_sh  [NO_ZONES];
  logic [FP16_W-1:0] depth_sh [NO_ZONES];
  logic [FP16_W-1:0] colc_sh;
  logic [FP16_W-1:0] rowc_sh;

  logic [FP16_W-1:0] w_nx     [2][3];
  logic [FP16_W-1:0] wt_nx;
  logic [FP16_W-1:0] a_nx     [2][NO_ZONES];
  logic [FP16_W-1:0] b_nx     [2][NO_ZONES];
  logic [R2_W-1:0]   r2_nx    [NO_ZONES];
  logic [FP16_W-1:0] conf_nx  [NO_ZONES];
  logic [FP16_W-1:0] depth_nx [NO_ZONES];
  logic [FP16_W-1:0] colc_nx;
  logic [FP16_W-1:0] rowc_nx;

  logic              hit;
  logic [3:0]        rgn;
  logic [3:0]        idx;
  logic [FP16_W-1:0] d16;

  assign rgn = cfg_addr_i[7:4];
  assign idx = cfg_addr_i[3:0];
  assign d16 = cfg_wdata_i[FP16_W-1:0];

  always_comb begin
    w_nx     = w_sh;
    wt_nx    = wt_sh;
    a_nx     = a_sh;
    b_nx     = b_sh;
    r2_nx    = r2_sh;
    conf_nx  = conf_sh;
    depth_nx = depth_sh;
    colc_nx  = colc_sh;
    rowc_nx  = rowc_sh;
    hit      = 1'b0;
    if (cfg_we_i) begin
      case (rgn)
        RGN_W: begin
          hit = 1'b1;
          case (idx)
            4'h0:    w_nx[0][0] = d16;
            4'h1:    w_nx[0][1] = d16;
            4'h2:    w_nx[0][2] = d16;
            4'h3:    w_nx[1][0] = d16;
            4'h4:    w_nx[1][1] = d16;
            4'h5:    w_nx[1][2] = d16;
            IDX_W_T: wt_nx      = d16;
            default: hit        = 1'b0;
          endcase
        end
        RGN_A0, RGN_A1, RGN_B0, RGN_B1, RGN_R2, RGN_CONF, RGN_DEPTH: begin
          for (int unsigned z = 0; z < NO_ZONES; z++) begin
            if (idx == 4'(z)) begin
              hit = 1'b1;
              case (rgn)
                RGN_A0:    a_nx[0][z]  = d16;
                RGN_A1:    a_nx[1][z]  = d16;
                RGN_B0:    b_nx[0][z]  = d16;
                RGN_B1:    b_nx[1][z]  = d16;
                RGN_R2:    r2_nx[z]    = cfg_wdata_i;
                RGN_CONF:  conf_nx[z]  = d16;
                RGN_DEPTH: depth_nx[z] = d16;
                default:   hit         = 1'b0;
              endcase
            end
          end
        end
        RGN_CTR: begin
          hit = 1'b1;
          case (idx)
            IDX_COL_CENTER: colc_nx = d16;
            IDX_ROW_CENTER: rowc_nx = d16;
            default:        hit     = 1'b0;
          endcase
        end
        default: hit = 1'b0;
      endcase
    end
  end

  // Commit copies the post-write shadow so a write landing in the commit cycle is included.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w_sh         <= '{default: '0};
      wt_sh        <= '0;
      a_sh         <= '{default: '0};
      b_sh         <= '{default: '0};
      r2_sh        <= '{default: '0};
      conf_sh      <= '{default: '0};
      depth_sh     <= '{default: '0};
      colc_sh      <= '0;
      rowc_sh      <= '0;
      w_o          <= '{default: '0};
      w_t_o        <= '0;
      a_o          <= '{default: '0};
      b_o          <= '{default: '0};
      r_squared_o  <= '{default: '0};
      confidence_o <= '{default: '0};
      depth_o      <= '{default: '0};
      col_center_o <= '0;
      row_center_o <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      w_sh      <= w_nx;
      wt_sh     <= wt_nx;
      a_sh      <= a_nx;
      b_sh      <= b_nx;
      r2_sh     <= r2_nx;
      conf_sh   <= conf_nx;
      depth_sh  <= depth_nx;
      colc_sh   <= colc_nx;
      rowc_sh   <= rowc_nx;
      cfg_err_o <= cfg_we_i && !hit;
      if (commit_i) begin
        w_o          <= w_nx;
        w_t_o        <= wt_nx;
        a_o          <= a_nx;
        b_o          <= b_nx;
        r_squared_o  <= r2_nx;
        confidence_o <= conf_nx;
        depth_o      <= depth_nx;
        col_center_o <= colc_nx;
        row_center_o <= rowc_nx;
      end
    end
  end

endmodule

// File: rtl/dfdd_frame_sequencer.sv
// Front-end sequencer for the dual-scale DfD pipeline: pixel handshake, col/row
// generation and frame-boundary coefficient commit. Drain timeout: DFDD_SEQ_DRAIN_TIMEOUT_EN.
module dfdd_frame_sequencer
  import dfdd_seq_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH   = 640,
  parameter int unsigned IMAGE_HEIGHT  = 480,
  parameter int unsigned NO_ZONES      = 1,
  parameter int unsigned DRAIN_TIMEOUT = 65535
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         pix_plus_i,
  input  logic [7:0]         pix_minus_i,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  output logic [7:0]         pix_plus_o,
  output logic [7:0]         pix_minus_o,
  output logic [COORD_W-1:0] col_o,
  output logic [COORD_W-1:0] row_o,
  output logic               valid_o,
  input  logic               out_valid_i,
  input  logic [COORD_W-1:0] out_col_i,
  input  logic [COORD_W-1:0] out_row_i,
  input  logic               cfg_we_i,
  input  logic [7:0]         cfg_addr_i,
  input  logic [CFG_W-1:0]   cfg_wdata_i,
  input  logic               cfg_commit_i,
  output logic               cfg_err_o,
  output logic [FP16_W-1:0]  w_o          [2][3],
  output logic [FP16_W-1:0]  w_t_o,
  output logic [FP16_W-1:0]  a_o          [2][NO_ZONES],
  output logic [FP16_W-1:0]  b_o          [2][NO_ZONES],
  output logic [R2_W-1:0]    r_squared_o  [NO_ZONES],
  output logic [FP16_W-1:0]  confidence_o [NO_ZONES],
  output logic [FP16_W-1:0]  depth_o      [NO_ZONES],
  output logic [FP16_W-1:0]  col_center_o,
  output logic [FP16_W-1:0]  row_center_o,
  output logic               commit_pending_o,
  output logic               busy_o,
  output logic [15:0]        frames_done_o,
  output logic               timeout_o
);

  if (NO_ZONES < 1 || NO_ZONES > 16 || DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > 65535 ||
      IMAGE_WIDTH < 1 || IMAGE_HEIGHT < 1) begin : g_bad_param
    $error("dfdd_frame_sequencer: parameter out of range");
  end

  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMAGE_WIDTH - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMAGE_HEIGHT - 1);

  seq_state_t         state;
  logic               ready_en;
  logic               commit_pending;
  logic               in_flight;
  logic [COORD_W-1:0] cnt_col;
  logic [COORD_W-1:0] cnt_row;
  logic               accept;
  logic               frame_end;
  logic               last_out;

`ifdef DFDD_SEQ_DRAIN_TIMEOUT_EN
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);
  logic [15:0] drain_cnt;
`else
  assign timeout_o = 1'b0;
`endif

  // ready_en keeps the handshake closed while reset is held; a pending commit in IDLE also closes it.
  assign pix_ready_o      = ready_en && ((state == IDLE && !commit_pending) || state == RUN);
  assign accept           = pix_valid_i && pix_ready_o;
  assign frame_end        = (cnt_col == COL_LAST) && (cnt_row == ROW_LAST);
  assign last_out         = out_valid_i && (out_col_i == COL_LAST) && (out_row_i == ROW_LAST);
  assign busy_o           = (state != IDLE);
  assign commit_pending_o = commit_pending;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      ready_en       <= 1'b0;
      commit_pending <= 1'b0;
      in_flight      <= 1'b0;
      cnt_col        <= '0;
      cnt_row        <= '0;
      col_o          <= '0;
      row_o          <= '0;
      valid_o        <= 1'b0;
      pix_plus_o     <= '0;
      pix_minus_o    <= '0;
      frames_done_o  <= '0;
`ifdef DFDD_SEQ_DRAIN_TIMEOUT_EN
      drain_cnt      <= '0;
      timeout_o      <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;
      valid_o  <= accept;
      if (accept) begin
        pix_plus_o  <= pix_plus_i;
        pix_minus_o <= pix_minus_i;
        col_o       <= cnt_col;
        row_o       <= cnt_row;
        if (cnt_col == COL_LAST) begin
          cnt_col <= '0;
          cnt_row <= (cnt_row == ROW_LAST) ? '0 : cnt_row + 1'b1;
        end else begin
          cnt_col <= cnt_col + 1'b1;
        end
      end

      if (last_out) frames_done_o <= frames_done_o + 1'b1;

      // A new frame ending wins over the previous frame's last output arriving.
      if (accept && frame_end) in_flight <= 1'b1;
      else if (last_out)       in_flight <= 1'b0;

      if (state == COMMIT)   commit_pending <= 1'b0;
      else if (cfg_commit_i) commit_pending <= 1'b1;

`ifdef DFDD_SEQ_DRAIN_TIMEOUT_EN
      if (state != DRAIN) drain_cnt <= '0;
`endif

      case (state)
        IDLE: begin
          if (commit_pending)    state <= in_flight ? DRAIN : COMMIT;
          else if (accept)       state <= frame_end ? IDLE : RUN;
        end
        RUN: begin
          if (accept && frame_end) state <= commit_pending ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (!in_flight) state <= COMMIT;
`ifdef DFDD_SEQ_DRAIN_TIMEOUT_EN
          else if (drain_cnt == DRAIN_LAST) begin
            state     <= COMMIT;
            timeout_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
`endif
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dfdd_coef_bank #(
    .NO_ZONES (NO_ZONES)
  ) u_coef_bank (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .commit_i     (state == COMMIT),
    .cfg_err_o    (cfg_err_o),
    .w_o          (w_o),
    .w_t_o        (w_t_o),
    .a_o          (a_o),
    .b_o          (b_o),
    .r_squared_o  (r_squared_o),
    .confidence_o (confidence_o),
    .depth_o      (depth_o),
    .col_center_o (col_center_o),
    .row_center_o (row_center_o)
  );

endmodule

// File: tb/tb_dfdd_frame_sequencer.sv
// Directed bench for dfdd_frame_sequencer on a 4x2 frame, one zone, DRAIN_TIMEOUT=10.
module tb_dfdd_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NZ = 1;
`ifdef DFDD_SEQ_DRAIN_TIMEOUT_EN
  localparam int DRAIN_WAIT = 5;
`else
  localparam int DRAIN_WAIT = 20;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  pix_plus_i, pix_minus_i;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [7:0]  pix_plus_o, pix_minus_o;
  logic [15:0] col_o, row_o;
  logic        valid_o;
  logic        out_valid_i;
  logic [15:0] out_col_i, out_row_i;
  logic        cfg_we_i;
  logic [7:0]  cfg_addr_i;
  logic [17:0] cfg_wdata_i;
  logic        cfg_commit_i;
  logic        cfg_err_o;
  logic [15:0] w_o [2][3];
  logic [15:0] w_t_o;
  logic [15:0] a_o [2][NZ];
  logic [15:0] b_o [2][NZ];
  logic [17:0] r_squared_o [NZ];
  logic [15:0] confidence_o [NZ];
  logic [15:0] depth_o [NZ];
  logic [15:0] col_center_o, row_center_o;
  logic        commit_pending_o, busy_o, timeout_o;
  logic [15:0] frames_done_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  dfdd_frame_sequencer #(
    .IMAGE_WIDTH   (W),
    .IMAGE_HEIGHT  (H),
    .NO_ZONES      (NZ),
    .DRAIN_TIMEOUT (10)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .pix_plus_i (pix_plus_i), .pix_minus_i (pix_minus_i),
    .pix_valid_i (pix_valid_i), .pix_ready_o (pix_ready_o),
    .pix_plus_o (pix_plus_o), .pix_minus_o (pix_minus_o),
    .col_o (col_o), .row_o (row_o), .valid_o (valid_o),
    .out_valid_i (out_valid_i), .out_col_i (out_col_i), .out_row_i (out_row_i),
    .cfg_we_i (cfg_we_i), .cfg_addr_i (cfg_addr_i), .cfg_wdata_i (cfg_wdata_i),
    .cfg_commit_i (cfg_commit_i), .cfg_err_o (cfg_err_o),
    .w_o (w_o), .w_t_o (w_t_o), .a_o (a_o), .b_o (b_o),
    .r_squared_o (r_squared_o), .confidence_o (confidence_o), .depth_o (depth_o),
    .col_center_o (col_center_o), .row_center_o (row_center_o),
    .commit_pending_o (commit_pending_o), .busy_o (busy_o),
    .frames_done_o (frames_done_o), .timeout_o (timeout_o)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  p;
    logic [7:0]  m;
    logic        e_valid;
    logic [15:0] e_col;
    logic [15:0] e_row;
  } pix_vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [17:0] data;
    logic        err;
  } cfg_vec_t;

  pix_vec_t pv [10];
  cfg_vec_t cv [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic stream(input int n, input int commit_at);
    pix_valid_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      pix_plus_i   = 8'(i);
      pix_minus_i  = 8'(255 - i);
      cfg_commit_i = (i == commit_at);
      cyc();
    end
    pix_valid_i  = 1'b0;
    cfg_commit_i = 1'b0;
  endtask

  initial begin
    pv[0] = '{1'b1, 8'h10, 8'hF0, 1'b1, 16'd0, 16'd0};
    pv[1] = '{1'b1, 8'h11, 8'hEF, 1'b1, 16'd1, 16'd0};
    pv[2] = '{1'b1, 8'h12, 8'hEE, 1'b1, 16'd2, 16'd0};
    pv[3] = '{1'b1, 8'h13, 8'hED, 1'b1, 16'd3, 16'd0};
    pv[4] = '{1'b1, 8'h14, 8'hEC, 1'b1, 16'd0, 16'd1};
    pv[5] = '{1'b1, 8'h15, 8'hEB, 1'b1, 16'd1, 16'd1};
    pv[6] = '{1'b1, 8'h16, 8'hEA, 1'b1, 16'd2, 16'd1};
    pv[7] = '{1'b1, 8'h17, 8'hE9, 1'b1, 16'd3, 16'd1};
    pv[8] = '{1'b0, 8'h00, 8'h00, 1'b0, 16'd3, 16'd1};
    pv[9] = '{1'b0, 8'h00, 8'h00, 1'b0, 16'd3, 16'd1};

    cv[0]  = '{8'h05, 18'h01111, 1'b0};
    cv[1]  = '{8'h06, 18'h02222, 1'b0};
    cv[2]  = '{8'h10, 18'h03333, 1'b0};
    cv[3]  = '{8'h11, 18'h0DEAD, 1'b1};
    cv[4]  = '{8'h20, 18'h04444, 1'b0};
    cv[5]  = '{8'h30, 18'h05555, 1'b0};
    cv[6]  = '{8'h95, 18'h0BEEF, 1'b1};
    cv[7]  = '{8'h40, 18'h06666, 1'b0};
    cv[8]  = '{8'h50, 18'h2ABCD, 1'b0};
    cv[9]  = '{8'h60, 18'h07777, 1'b0};
    cv[10] = '{8'h70, 18'h08888, 1'b0};
    cv[11] = '{8'h81, 18'h00099, 1'b0};
    cv[12] = '{8'h07, 18'h0AAAA, 1'b1};
    cv[13] = '{8'h80, 18'h00140, 1'b0};

    rst_i = 1'b0;
    pix_plus_i = '0; pix_minus_i = '0; pix_valid_i = 1'b0;
    out_valid_i = 1'b0; out_col_i = '0; out_row_i = '0;
    cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0; cfg_commit_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", pix_ready_o, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_col", col_o, 16'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_frames", frames_done_o, 16'd0);
    chk("rst_w00", w_o[0][0], 16'd0);
    chk("rst_timeout", timeout_o, 1'b0);
    rst_i = 1'b1;
    cyc();
    chk("ready_after_rst", pix_ready_o, 1'b1);

    // Frame 1: table-driven continuous stream
    for (int i = 0; i < 10; i++) begin
      pix_valid_i = pv[i].vld;
      pix_plus_i  = pv[i].p;
      pix_minus_i = pv[i].m;
      chk("tbl_ready", pix_ready_o, 1'b1);
      cyc();
      chk("tbl_valid", valid_o, pv[i].e_valid);
      chk("tbl_col", col_o, pv[i].e_col);
      chk("tbl_row", row_o, pv[i].e_row);
      if (pv[i].e_valid) begin
        chk("tbl_plus", pix_plus_o, pv[i].p);
        chk("tbl_minus", pix_minus_o, pv[i].m);
      end
    end
    chk("f1_busy", busy_o, 1'b0);
    out_valid_i = 1'b1; out_col_i = 16'(W - 1); out_row_i = 16'(H - 1);
    cyc();
    out_valid_i = 1'b0;
    chk("f1_frames_done", frames_done_o, 16'd1);

    // Frame 2: write w[0][0], commit mid-frame, late pipeline output
    cfg_we_i = 1'b1; cfg_addr_i = 8'h00; cfg_wdata_i = 18'h03C00;
    cyc();
    cfg_we_i = 1'b0;
    chk("w00_write_err", cfg_err_o, 1'b0);
    stream(8, 3);
    chk("f2_pending", commit_pending_o, 1'b1);
    chk("f2_drain_busy", busy_o, 1'b1);
    for (int k = 0; k < DRAIN_WAIT; k++) begin
      chk("drain_ready", pix_ready_o, 1'b0);
      chk("drain_w00", w_o[0][0], 16'd0);
      cyc();
    end
    out_valid_i = 1'b1; out_col_i = 16'(W - 1); out_row_i = 16'(H - 1);
    cyc();
    out_valid_i = 1'b0;
    chk("f2_frames_done", frames_done_o, 16'd2);
    chk("f2_w00_pre", w_o[0][0], 16'd0);
    cyc();
    chk("commit_busy", busy_o, 1'b1);
    chk("commit_ready", pix_ready_o, 1'b0);
    chk("commit_w00_pre", w_o[0][0], 16'd0);
    cyc();
    chk("commit_w00", w_o[0][0], 16'h3C00);
    chk("commit_pend_clr", commit_pending_o, 1'b0);
    chk("commit_idle", busy_o, 1'b0);
    chk("commit_timeout", timeout_o, 1'b0);

    // Address map, unmapped writes, and a write+commit in the same cycle
    for (int i = 0; i < 14; i++) begin
      cfg_we_i     = 1'b1;
      cfg_addr_i   = cv[i].addr;
      cfg_wdata_i  = cv[i].data;
      cfg_commit_i = (i == 13);
      cyc();
      chk("cfg_err", cfg_err_o, cv[i].err);
    end
    cfg_we_i = 1'b0; cfg_commit_i = 1'b0;
    chk("wc_pending", commit_pending_o, 1'b1);
    chk("wc_idle", busy_o, 1'b0);
    chk("wc_colc_pre", col_center_o, 16'd0);
    cyc();
    chk("wc_commit_busy", busy_o, 1'b1);
    chk("wc_err_cleared", cfg_err_o, 1'b0);
    chk("wc_colc_pre2", col_center_o, 16'd0);
    cyc();
    chk("act_col_center", col_center_o, 16'h0140);
    chk("act_row_center", row_center_o, 16'h0099);
    chk("act_w12", w_o[1][2], 16'h1111);
    chk("act_w01", w_o[0][1], 16'h0000);
    chk("act_w00", w_o[0][0], 16'h3C00);
    chk("act_w_t", w_t_o, 16'h2222);
    chk("act_a0", a_o[0][0], 16'h3333);
    chk("act_a1", a_o[1][0], 16'h4444);
    chk("act_b0", b_o[0][0], 16'h5555);
    chk("act_b1", b_o[1][0], 16'h6666);
    chk("act_r2", r_squared_o[0], 18'h2ABCD);
    chk("act_conf", confidence_o[0], 16'h7777);
    chk("act_depth", depth_o[0], 16'h8888);
    chk("wc_pend_clr", commit_pending_o, 1'b0);

`ifdef DFDD_SEQ_DRAIN_TIMEOUT_EN
    // Drain timeout: last output never returns
    stream(8, 3);
    for (int k = 1; k < 10; k++) begin
      cyc();
      chk("to_drain_ready", pix_ready_o, 1'b0);
      chk("to_not_yet", timeout_o, 1'b0);
    end
    cyc();
    chk("to_set", timeout_o, 1'b1);
    chk("to_commit_pend", commit_pending_o, 1'b1);
    cyc();
    chk("to_pend_clr", commit_pending_o, 1'b0);
    chk("to_idle", busy_o, 1'b0);
    repeat (3) cyc();
    chk("to_sticky", timeout_o, 1'b1);
`endif

    // Reset mid-RUN with a commit pending
    stream(3, 0);
    chk("mr_pending", commit_pending_o, 1'b1);
    chk("mr_col", col_o, 16'd2);
    chk("mr_busy", busy_o, 1'b1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mr_rst_valid", valid_o, 1'b0);
    chk("mr_rst_col", col_o, 16'd0);
    chk("mr_rst_ready", pix_ready_o, 1'b0);
    chk("mr_rst_pend", commit_pending_o, 1'b0);
    chk("mr_rst_busy", busy_o, 1'b0);
    chk("mr_rst_frames", frames_done_o, 16'd0);
    chk("mr_rst_w00", w_o[0][0], 16'd0);
    chk("mr_rst_colc", col_center_o, 16'd0);
    chk("mr_rst_plus", pix_plus_o, 8'd0);
    chk("mr_rst_timeout", timeout_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cyc();
    pix_valid_i = 1'b1; pix_plus_i = 8'hA5; pix_minus_i = 8'h5A;
    cyc();
    chk("nf_valid", valid_o, 1'b1);
    chk("nf_col", col_o, 16'd0);
    chk("nf_row", row_o, 16'd0);
    chk("nf_pend", commit_pending_o, 1'b0);
    cyc();
    pix_valid_i = 1'b0;
    chk("nf_col1", col_o, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
